// File: rtl/mips_lsu_if.sv
// Load/store unit bus: execute-stage request, writeback response, data-memory port, error flag.
// Latency: none, signal bundle only.
// Backpressure: req_ready throttles requests and resp_ready holds responses.
interface mips_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    logic        err;

    logic [31:0] mem_address;
    logic [31:0] write_data;
    logic [1:0]  byte_number;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] read_data;

    modport slave (
        input  req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_data, resp_rd,
        input  resp_ready,
        output err,
        output mem_address, write_data, byte_number, sig_mem_read, sig_mem_write,
        input  read_data
    );

    modport master (
        output req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_data, resp_rd,
        output resp_ready,
        input  err,
        input  mem_address, write_data, byte_number, sig_mem_read, sig_mem_write,
        output read_data
    );
endinterface

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one request at a time to a word-addressed data memory; MIPS_LSU_SIGN_EXT_EN adds signed sub-word loads.
// Latency: load response 2 cycles after the accept cycle, store occupies accept + 1 write cycle.
// Backpressure: req_ready only in IDLE; a response is held in RESP until resp_ready.
module mips_lsu #(
    parameter int MEM_WORDS = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    mips_lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_BYTE   = 2'b10;
    localparam logic [1:0]  SZ_ILL    = 2'b11;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        err_q, err_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] write_data_q, write_data_d;
    logic [1:0]  byte_number_q, byte_number_d;
    logic [31:0] load_value;
    logic        accept;
    logic        illegal;

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign illegal = (bus.req_size == SZ_ILL) || (bus.req_addr >= MEM_LIMIT);

`ifdef MIPS_LSU_SIGN_EXT_EN
    logic signed_q, signed_d;

    always_comb begin
        load_value = bus.read_data;
        if (signed_q && (byte_number_q == SZ_HALF)) begin
            load_value = {{16{bus.read_data[15]}}, bus.read_data[15:0]};
        end else if (signed_q && (byte_number_q == SZ_BYTE)) begin
            load_value = {{24{bus.read_data[7]}}, bus.read_data[7:0]};
        end
    end

    always_comb begin
        signed_d = signed_q;
        if (accept && !illegal) begin
            signed_d = bus.req_signed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signed_q <= 1'b0;
        end else begin
            signed_q <= signed_d;
        end
    end
`else
    // Memory already zero-extends sub-word reads.
    assign load_value = bus.read_data;
`endif

    always_comb begin
        state_d       = state_q;
        resp_data_d   = resp_data_q;
        resp_rd_d     = resp_rd_q;
        err_d         = err_q;
        mem_address_d = mem_address_q;
        write_data_d  = write_data_q;
        byte_number_d = byte_number_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.req_is_store) begin
                        resp_rd_d = bus.req_rd;
                    end
                    if (illegal) begin
                        // Illegal loads still answer so writeback is not left waiting.
                        err_d = 1'b1;
                        if (!bus.req_is_store) begin
                            resp_data_d = '0;
                            state_d     = RESP;
                        end
                    end else begin
                        mem_address_d = bus.req_addr;
                        byte_number_d = bus.req_size;
                        if (bus.req_is_store) begin
                            write_data_d = bus.req_wdata;
                            state_d      = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                resp_data_d = load_value;
                state_d     = RESP;
            end
            WRITE: begin
                state_d = IDLE;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            resp_data_q   <= '0;
            resp_rd_q     <= '0;
            err_q         <= 1'b0;
            mem_address_q <= '0;
            write_data_q  <= '0;
            byte_number_q <= '0;
        end else begin
            state_q       <= state_d;
            resp_data_q   <= resp_data_d;
            resp_rd_q     <= resp_rd_d;
            err_q         <= err_d;
            mem_address_q <= mem_address_d;
            write_data_q  <= write_data_d;
            byte_number_q <= byte_number_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.resp_valid    = (state_q == RESP);
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_rd       = resp_rd_q;
    assign bus.err           = err_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.write_data    = write_data_q;
    assign bus.byte_number   = byte_number_q;
    assign bus.sig_mem_read  = (state_q == READ);
    assign bus.sig_mem_write = (state_q == WRITE);

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu with a behavioural data memory; expectations follow MIPS_LSU_SIGN_EXT_EN.
// Latency: inputs driven 1ns after the rising edge, outputs sampled there too.
// Backpressure: resp_ready held low for several cycles in one step.
module tb_mips_lsu;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [31:0] mem [0:255];

    mips_lsu_if bus ();

    mips_lsu #(.MEM_WORDS(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory, sub-word reads zero-extended from the low bits.
    always_comb begin
        bus.read_data = 32'h0;
        if (bus.mem_address < 32'd256) begin
            case (bus.byte_number)
                2'b01:   bus.read_data = {16'h0, mem[bus.mem_address[7:0]][15:0]};
                2'b10:   bus.read_data = {24'h0, mem[bus.mem_address[7:0]][7:0]};
                default: bus.read_data = mem[bus.mem_address[7:0]];
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.sig_mem_write && (bus.mem_address < 32'd256)) begin
            case (bus.byte_number)
                2'b01:   mem[bus.mem_address[7:0]][15:0] <= bus.write_data[15:0];
                2'b10:   mem[bus.mem_address[7:0]][7:0]  <= bus.write_data[7:0];
                default: mem[bus.mem_address[7:0]]       <= bus.write_data;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns 1ns after the accepting edge.
    task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        bus.req_is_store = st;
        bus.req_size     = sz;
        bus.req_signed   = sg;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        bus.req_valid    = 1'b1;
        tick();
        bus.req_valid    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_b;
        logic [31:0] exp_h;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_signed   = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_rd       = 5'd0;
        bus.resp_ready   = 1'b1;
        #2;
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        check("rst_err", {31'h0, bus.err}, 32'd0);
        check("rst_strobes", {30'h0, bus.sig_mem_read, bus.sig_mem_write}, 32'd0);
        check("rst_mem_address", bus.mem_address, 32'h0);
        check("rst_write_data", bus.write_data, 32'h0);
        check("rst_byte_number", {30'h0, bus.byte_number}, 32'd0);
        check("rst_resp_data", bus.resp_data, 32'h0);
        check("rst_resp_rd", {27'h0, bus.resp_rd}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Word store then word load at address 5.
        check("st5_req_ready", {31'h0, bus.req_ready}, 32'd1);
        issue(1'b1, 2'b00, 1'b0, 32'd5, 32'hDEADBEEF, 5'd0);
        check("st5_write", {31'h0, bus.sig_mem_write}, 32'd1);
        check("st5_no_read", {31'h0, bus.sig_mem_read}, 32'd0);
        check("st5_addr", bus.mem_address, 32'd5);
        check("st5_wdata", bus.write_data, 32'hDEADBEEF);
        check("st5_bytenum", {30'h0, bus.byte_number}, 32'd0);
        check("st5_busy", {31'h0, bus.req_ready}, 32'd0);
        tick();
        check("st5_write_done", {31'h0, bus.sig_mem_write}, 32'd0);
        check("st5_idle", {31'h0, bus.req_ready}, 32'd1);
        check("st5_addr_hold", bus.mem_address, 32'd5);
        check("st5_no_resp", {31'h0, bus.resp_valid}, 32'd0);

        issue(1'b0, 2'b00, 1'b0, 32'd5, 32'h0, 5'd3);
        check("ld5_read", {31'h0, bus.sig_mem_read}, 32'd1);
        check("ld5_not_yet", {31'h0, bus.resp_valid}, 32'd0);
        tick();
        check("ld5_valid", {31'h0, bus.resp_valid}, 32'd1);
        check("ld5_data", bus.resp_data, 32'hDEADBEEF);
        check("ld5_rd", {27'h0, bus.resp_rd}, 32'd3);
        check("ld5_read_done", {31'h0, bus.sig_mem_read}, 32'd0);
        tick();
        check("ld5_idle", {31'h0, bus.req_ready}, 32'd1);
        check("ld5_valid_drop", {31'h0, bus.resp_valid}, 32'd0);

        // Sub-word loads.
`ifdef MIPS_LSU_SIGN_EXT_EN
        exp_b = 32'hFFFFFFEF;
        exp_h = 32'hFFFFBEEF;
`else
        exp_b = 32'h000000EF;
        exp_h = 32'h0000BEEF;
`endif
        issue(1'b0, 2'b10, 1'b1, 32'd5, 32'h0, 5'd7);
        check("lb_signed_bytenum", {30'h0, bus.byte_number}, 32'd2);
        tick();
        check("lb_signed_data", bus.resp_data, exp_b);
        tick();
        issue(1'b0, 2'b01, 1'b1, 32'd5, 32'h0, 5'd8);
        tick();
        check("lh_signed_data", bus.resp_data, exp_h);
        tick();
        issue(1'b0, 2'b10, 1'b0, 32'd5, 32'h0, 5'd9);
        tick();
        check("lb_unsigned_data", bus.resp_data, 32'h000000EF);
        tick();

        // Writeback stall.
        bus.resp_ready = 1'b0;
        issue(1'b0, 2'b00, 1'b0, 32'd5, 32'h0, 5'd10);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", {31'h0, bus.resp_valid}, 32'd1);
            check("stall_data", bus.resp_data, 32'hDEADBEEF);
            check("stall_rd", {27'h0, bus.resp_rd}, 32'd10);
            check("stall_req_ready", {31'h0, bus.req_ready}, 32'd0);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        check("stall_release_valid", {31'h0, bus.resp_valid}, 32'd0);
        check("stall_release_idle", {31'h0, bus.req_ready}, 32'd1);

        // Out-of-range store, then legal load.
        issue(1'b1, 2'b00, 1'b0, 32'd300, 32'h12345678, 5'd0);
        check("bad_st_no_write", {31'h0, bus.sig_mem_write}, 32'd0);
        check("bad_st_err", {31'h0, bus.err}, 32'd1);
        check("bad_st_idle", {31'h0, bus.req_ready}, 32'd1);
        check("bad_st_addr_hold", bus.mem_address, 32'd5);
        tick();
        check("bad_st_err_sticky", {31'h0, bus.err}, 32'd1);
        issue(1'b0, 2'b00, 1'b0, 32'd5, 32'h0, 5'd4);
        check("after_bad_read", {31'h0, bus.sig_mem_read}, 32'd1);
        tick();
        check("after_bad_data", bus.resp_data, 32'hDEADBEEF);
        check("after_bad_rd", {27'h0, bus.resp_rd}, 32'd4);
        check("after_bad_err", {31'h0, bus.err}, 32'd1);
        tick();

        // Illegal size load answers immediately with zero.
        issue(1'b0, 2'b11, 1'b0, 32'd2, 32'h0, 5'd6);
        check("bad_ld_valid", {31'h0, bus.resp_valid}, 32'd1);
        check("bad_ld_data", bus.resp_data, 32'h0);
        check("bad_ld_rd", {27'h0, bus.resp_rd}, 32'd6);
        check("bad_ld_no_read", {31'h0, bus.sig_mem_read}, 32'd0);
        tick();
        check("bad_ld_done", {31'h0, bus.resp_valid}, 32'd0);

        // Highest legal address.
        issue(1'b1, 2'b00, 1'b0, 32'd255, 32'hA5A50F0F, 5'd0);
        check("top_st_write", {31'h0, bus.sig_mem_write}, 32'd1);
        check("top_st_addr", bus.mem_address, 32'd255);
        tick();
        issue(1'b0, 2'b01, 1'b0, 32'd255, 32'h0, 5'd12);
        tick();
        check("top_lh_data", bus.resp_data, 32'h00000F0F);
        tick();

        // Reset during READ.
        issue(1'b0, 2'b00, 1'b0, 32'd5, 32'h0, 5'd11);
        check("abort_read", {31'h0, bus.sig_mem_read}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_strobes", {30'h0, bus.sig_mem_read, bus.sig_mem_write}, 32'd0);
        check("abort_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        check("abort_err", {31'h0, bus.err}, 32'd0);
        check("abort_mem_address", bus.mem_address, 32'h0);
        check("abort_write_data", bus.write_data, 32'h0);
        check("abort_resp_data", bus.resp_data, 32'h0);
        check("abort_resp_rd", {27'h0, bus.resp_rd}, 32'd0);
        check("abort_bytenum", {30'h0, bus.byte_number}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_abort_ready", {31'h0, bus.req_ready}, 32'd1);
        check("post_abort_no_resp", {31'h0, bus.resp_valid}, 32'd0);
        check("post_abort_no_read", {31'h0, bus.sig_mem_read}, 32'd0);
        tick();
        check("post_abort_still_idle", {31'h0, bus.resp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
